snake_sound_seq: RTL and testbench
==================================

# snake_sound_seq

Sound-effect sequencer for the snake game: turns single-cycle game events (food eaten, crash/game over) into timed note sequences and drives the buzzer tone generator's period input. Sits between the game-logic FSM and the buzzer driver. It presents an 18-bit tone period, with 0 meaning silence, that the buzzer divides into a 50 % square wave. It owns all note timing, gaps, priority and queuing, so game logic only pulses events.

## Interface
- NOTE_LEN, 25'd5000000: cycles each note is held (100 ms at 50 MHz); legal range 1..2^25-1.
- GAP_LEN, 25'd1250000: silent cycles after every note (25 ms); 0 means no gap.
- DO, 18'd190839: tone period for 262 Hz.
- MI, 18'd151515: tone period for 330 Hz.
- SO, 18'd127550: tone period for 392 Hz.
- sys_clk  in  1  system clock, 50 MHz; single clock domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- eat_evt  in  1  one-cycle pulse, food eaten; synchronous to sys_clk.
- crash_evt  in  1  one-cycle pulse, snake crashed; synchronous to sys_clk.
- mute  in  1  level; silences output without stopping sequencing.
- freq_data  out  18  tone period to buzzer; 0 = silent; registered.
- tone_on  out  1  high when freq_data != 0; registered.
- busy  out  1  sequence in progress; registered.
- done  out  1  one-cycle pulse when a sequence completes; registered.

## Operation
- Sequences:
  - EAT = DO, SO (2 notes).
  - CRASH = SO, MI, DO (3 notes).
  - Every note is followed by its gap, including the last note.
- States:
  - IDLE: freq_data 0, busy 0.
  - NOTE: freq_data = current note period.
  - GAP: freq_data 0, busy 1.
- Transitions:
  - IDLE->NOTE on an event.
  - NOTE->GAP after NOTE_LEN cycles; NOTE->next NOTE directly if GAP_LEN = 0.
  - GAP->NOTE (next index) after GAP_LEN cycles.
  - Last note's gap end -> IDLE, or -> NOTE of the pending EAT.
- Registers: one 25-bit duration counter, a 2-bit note index, a 1-bit sequence id (EAT/CRASH) and a 1-bit eat_pending flag.
- Priority and queuing:
  - eat_evt and crash_evt in the same cycle: CRASH starts, the eat is dropped.
  - crash_evt during EAT: EAT is aborted immediately, CRASH starts from note 0, eat_pending is cleared. No done pulse is issued for the aborted EAT.
  - crash_evt during CRASH: CRASH restarts from note 0.
  - eat_evt during CRASH: dropped.
  - eat_evt during EAT: sets eat_pending; further eats while pending are dropped (depth 1).
  - On EAT completion with eat_pending set: done pulses, the new EAT starts on the same edge, busy stays 1, eat_pending clears.
- mute: forces freq_data = 0 and tone_on = 0 while asserted. Counters, state and busy/done are unaffected. Release mid-note resumes the current note's period on the next cycle.
- Reset values: freq_data 0, tone_on 0, busy 0, done 0, state IDLE, counter 0, index 0, eat_pending 0.

## Timing
- Latency: an event sampled at edge k gives freq_data = first note, busy = 1 after edge k (1-cycle latency).
- freq_data holds each note for exactly NOTE_LEN cycles, then 0 for exactly GAP_LEN cycles.
- EAT length from edge k: done pulses and busy falls after edge k + 2·(NOTE_LEN+GAP_LEN). CRASH length is 3·(NOTE_LEN+GAP_LEN).
- done is high for exactly one cycle, coincident with the first cycle busy is 0 (or with the restart edge for a pending EAT).
- Abort/restart by crash_evt at edge j: freq_data = SO after edge j, counter reset to 0.
- Asynchronous reset mid-sequence clears all outputs immediately. After release, the block waits in IDLE for a new event; no queued event survives reset.

## Test plan
- EAT (NOTE_LEN=8, GAP_LEN=2), eat_evt at edge 0 -> freq_data
  - DO after edges 0–7
  - 0 after edges 8–9
  - SO after edges 10–17
  - 0 after edges 18–19
  - done=1 and busy=0 after edge 20
- CRASH with the same params -> SO / 0 / MI / 0 / DO / 0, segments of 8/2/8/2/8/2 cycles; done after edge 30.
- Simultaneous eat_evt + crash_evt at edge 0 -> CRASH sequence; no eat plays afterwards; single done after edge 30.
- crash_evt at edge 12 during EAT -> freq_data = SO after edge 12; no done for the aborted EAT; done after edge 42.
- Two eat_evt at edges 0 and 5, third at 6 -> done after edge 20, DO again after edge 20, busy stays 1, second done after edge 40; third eat dropped.
- mute high edges 3–5 during EAT -> freq_data/tone_on 0 for those cycles, DO after edge 6, timing unchanged. Then sys_rst_n low at edge 14 -> all outputs 0 at once; IDLE after release.

Source files
------------

// File: rtl/snake_sound_seq.sv
`default_nettype none
// ============================================================================
//  Module   : snake_sound_seq
//  Purpose  : Sound-effect sequencer for the snake game. Converts one-cycle
//             game events (food eaten, crash) into timed note sequences and
//             presents the buzzer's tone period (0 = silent).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    sys_clk    in   1   system clock (single domain)
//    sys_rst_n  in   1   asynchronous active-low reset
//    eat_evt    in   1   one-cycle pulse, food eaten
//    crash_evt  in   1   one-cycle pulse, snake crashed
//    mute       in   1   level, silences output; sequencing continues
//    freq_data  out  18  tone period to buzzer, 0 = silent (registered)
//    tone_on    out  1   high when freq_data != 0 (registered)
//    busy       out  1   sequence in progress (registered)
//    done       out  1   one-cycle pulse when a sequence completes
// ============================================================================
module snake_sound_seq #(
  parameter logic [24:0] NOTE_LEN = 25'd5000000,
  parameter logic [24:0] GAP_LEN  = 25'd1250000,
  parameter logic [17:0] DO       = 18'd190839,
  parameter logic [17:0] MI       = 18'd151515,
  parameter logic [17:0] SO       = 18'd127550
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        eat_evt,
  input  logic        crash_evt,
  input  logic        mute,
  output logic [17:0] freq_data,
  output logic        tone_on,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic SEQ_EAT   = 1'b0;
  localparam logic SEQ_CRASH = 1'b1;

  state_t      state_q, state_d;
  logic [24:0] cnt_q,   cnt_d;
  logic [1:0]  idx_q,   idx_d;
  logic        seq_q,   seq_d;
  logic        pend_q,  pend_d;
  logic [17:0] freq_q,  freq_d;
  logic        tone_q,  tone_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic w_pend;
  logic w_last;
  logic w_note_end;
  logic w_gap_end;
  logic w_step;

  // Note table: EAT = DO, SO ; CRASH = SO, MI, DO
  function automatic logic [17:0] note_period(input logic seq, input logic [1:0] idx);
    logic [17:0] p;
    p = 18'd0;
    if (seq == SEQ_EAT) begin
      p = (idx == 2'd0) ? DO : SO;
    end else begin
      case (idx)
        2'd0:    p = SO;
        2'd1:    p = MI;
        default: p = DO;
      endcase
    end
    return p;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    pend_d  = pend_q;
    done_d  = 1'b0;

    // An eat arriving on the very edge an EAT finishes still counts as queued.
    w_pend     = pend_q | (eat_evt & (state_q != S_IDLE) & (seq_q == SEQ_EAT));
    w_last     = (seq_q == SEQ_CRASH) ? (idx_q == 2'd2) : (idx_q == 2'd1);
    w_note_end = (state_q == S_NOTE) && (cnt_q == NOTE_LEN - 25'd1);
    w_gap_end  = (state_q == S_GAP)  && (cnt_q == GAP_LEN - 25'd1);
    // With no gap configured, a note's end advances straight to the next note.
    w_step     = w_gap_end || (w_note_end && (GAP_LEN == 25'd0));

    if (crash_evt) begin
      // Crash always wins: aborts/restarts anything and drops queued eats.
      state_d = S_NOTE;
      seq_d   = SEQ_CRASH;
      idx_d   = 2'd0;
      cnt_d   = 25'd0;
      pend_d  = 1'b0;
    end else if (eat_evt && (state_q == S_IDLE)) begin
      state_d = S_NOTE;
      seq_d   = SEQ_EAT;
      idx_d   = 2'd0;
      cnt_d   = 25'd0;
    end else if ((state_q == S_NOTE) || (state_q == S_GAP)) begin
      pend_d = w_pend;
      if (w_step) begin
        cnt_d = 25'd0;
        if (w_last) begin
          done_d = 1'b1;
          idx_d  = 2'd0;
          if (w_pend) begin
            // Back-to-back EAT starts on the completion edge; busy never drops.
            state_d = S_NOTE;
            seq_d   = SEQ_EAT;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_NOTE;
        end
      end else if (w_note_end) begin
        cnt_d   = 25'd0;
        state_d = S_GAP;
      end else begin
        cnt_d = cnt_q + 25'd1;
      end
    end else begin
      // Idle, or an unreachable encoding: settle in IDLE.
      state_d = S_IDLE;
      cnt_d   = 25'd0;
      idx_d   = 2'd0;
      pend_d  = 1'b0;
    end

    // Outputs follow the next state so they are aligned with it after the edge.
    freq_d = ((state_d == S_NOTE) && !mute) ? note_period(seq_d, idx_d) : 18'd0;
    tone_d = (freq_d != 18'd0);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 25'd0;
      idx_q   <= 2'd0;
      seq_q   <= SEQ_EAT;
      pend_q  <= 1'b0;
      freq_q  <= 18'd0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      pend_q  <= pend_d;
      freq_q  <= freq_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign freq_data = freq_q;
  assign tone_on   = tone_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_sound_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_sound_seq
//  Purpose  : Self-checking bench for snake_sound_seq. Expected waveforms are
//             described as tables of output segments per scenario; expected
//             values are queued when stimulus is driven and compared after
//             the clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snake_sound_seq;

  localparam logic [17:0] P_DO = 18'd190839;
  localparam logic [17:0] P_MI = 18'd151515;
  localparam logic [17:0] P_SO = 18'd127550;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        eat_evt   = 1'b0;
  logic        crash_evt = 1'b0;
  logic        mute      = 1'b0;
  logic [17:0] freq_data, freq0;
  logic        tone_on, busy, done;
  logic        tone0, busy0, done0;

  snake_sound_seq #(
    .NOTE_LEN(25'd8), .GAP_LEN(25'd2), .DO(P_DO), .MI(P_MI), .SO(P_SO)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .eat_evt(eat_evt),
    .crash_evt(crash_evt), .mute(mute), .freq_data(freq_data),
    .tone_on(tone_on), .busy(busy), .done(done)
  );

  // Minimum note length, no gap.
  snake_sound_seq #(
    .NOTE_LEN(25'd1), .GAP_LEN(25'd0), .DO(P_DO), .MI(P_MI), .SO(P_SO)
  ) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .eat_evt(eat_evt),
    .crash_evt(crash_evt), .mute(mute), .freq_data(freq0),
    .tone_on(tone0), .busy(busy0), .done(done0)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          from_e;
    int          to_e;
    logic [17:0] f;
    bit          busy;
    bit          done;
  } seg_t;

  typedef struct {
    int e;
    bit eat;
    bit crash;
  } ev_t;

  typedef struct {
    int          e;
    logic [17:0] f;
    bit          tone;
    bit          busy;
    bit          done;
  } exp_t;

  seg_t segs[$];
  ev_t  evs[$];
  exp_t exp_q[$];
  int   mute_from = -1;
  int   mute_to   = -1;
  int   tests     = 0;
  int   fails     = 0;

  task automatic check(input string name,
                       input logic [17:0] af, input logic at, input logic ab, input logic ad,
                       input logic [17:0] ef, input logic et, input logic eb, input logic ed);
    tests++;
    if (af !== ef || at !== et || ab !== eb || ad !== ed) begin
      fails++;
      $display("FAIL %s: got freq=%0d tone=%0b busy=%0b done=%0b, want freq=%0d tone=%0b busy=%0b done=%0b",
               name, af, at, ab, ad, ef, et, eb, ed);
    end
  endtask

  task automatic add_seg(input int a, input int b, input logic [17:0] f, input bit bz, input bit dn);
    seg_t s;
    s.from_e = a; s.to_e = b; s.f = f; s.busy = bz; s.done = dn;
    segs.push_back(s);
  endtask

  task automatic add_ev(input int e, input bit eat, input bit crash);
    ev_t v;
    v.e = e; v.eat = eat; v.crash = crash;
    evs.push_back(v);
  endtask

  // Drive the event table edge by edge; outputs after edge e must match the
  // segment covering e (no segment = idle: silent, not busy, no done).
  task automatic run(input string name, input int nedges);
    exp_t x, y;
    for (int e = 0; e < nedges; e++) begin
      @(negedge sys_clk);
      eat_evt   = 1'b0;
      crash_evt = 1'b0;
      foreach (evs[i]) begin
        if (evs[i].e == e) begin
          if (evs[i].eat)   eat_evt   = 1'b1;
          if (evs[i].crash) crash_evt = 1'b1;
        end
      end
      mute = (e >= mute_from) && (e <= mute_to);
      x.e = e; x.f = 18'd0; x.busy = 1'b0; x.done = 1'b0;
      foreach (segs[i]) begin
        if (e >= segs[i].from_e && e <= segs[i].to_e) begin
          x.f = segs[i].f; x.busy = segs[i].busy; x.done = segs[i].done;
        end
      end
      x.tone = (x.f != 18'd0);
      exp_q.push_back(x);
      @(posedge sys_clk);
      #1;
      y = exp_q.pop_front();
      check($sformatf("%s@%0d", name, y.e), freq_data, tone_on, busy, done,
            y.f, y.tone, y.busy, y.done);
    end
    @(negedge sys_clk);
    eat_evt = 1'b0; crash_evt = 1'b0; mute = 1'b0;
    segs.delete(); evs.delete();
    mute_from = -1; mute_to = -1;
  endtask

  task automatic crash_segs(input int s);
    add_seg(s,      s + 7,  P_SO, 1, 0);
    add_seg(s + 8,  s + 9,  0,    1, 0);
    add_seg(s + 10, s + 17, P_MI, 1, 0);
    add_seg(s + 18, s + 19, 0,    1, 0);
    add_seg(s + 20, s + 27, P_DO, 1, 0);
    add_seg(s + 28, s + 29, 0,    1, 0);
    add_seg(s + 30, s + 30, 0,    0, 1);
  endtask

  initial begin
    logic [17:0] ef;
    bit          eb, ed;

    // Reset state
    #2 sys_rst_n = 1'b0;
    #1;
    check("reset", freq_data, tone_on, busy, done, 18'd0, 1'b0, 1'b0, 1'b0);
    check("reset0", freq0, tone0, busy0, done0, 18'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Plain EAT
    add_ev(0, 1, 0);
    add_seg(0, 7, P_DO, 1, 0);  add_seg(8, 9, 0, 1, 0);
    add_seg(10, 17, P_SO, 1, 0); add_seg(18, 19, 0, 1, 0);
    add_seg(20, 20, 0, 0, 1);
    run("eat", 24);

    // Plain CRASH
    add_ev(0, 0, 1);
    crash_segs(0);
    run("crash", 34);

    // Simultaneous events: crash wins, eat never plays
    add_ev(0, 1, 1);
    crash_segs(0);
    run("both", 40);

    // Crash aborts EAT during its second note
    add_ev(0, 1, 0);
    add_ev(12, 0, 1);
    add_seg(0, 7, P_DO, 1, 0); add_seg(8, 9, 0, 1, 0);
    add_seg(10, 11, P_SO, 1, 0);
    crash_segs(12);
    run("abort", 46);

    // Queued eat (depth 1): third eat dropped
    add_ev(0, 1, 0); add_ev(5, 1, 0); add_ev(6, 1, 0);
    add_seg(0, 7, P_DO, 1, 0);   add_seg(8, 9, 0, 1, 0);
    add_seg(10, 17, P_SO, 1, 0); add_seg(18, 19, 0, 1, 0);
    add_seg(20, 20, P_DO, 1, 1); add_seg(21, 27, P_DO, 1, 0);
    add_seg(28, 29, 0, 1, 0);    add_seg(30, 37, P_SO, 1, 0);
    add_seg(38, 39, 0, 1, 0);    add_seg(40, 40, 0, 0, 1);
    run("queue", 44);

    // Eat during CRASH is dropped
    add_ev(0, 0, 1); add_ev(4, 1, 0);
    crash_segs(0);
    run("crash_eat", 40);

    // Mute mid-note, then async reset mid-sequence with an eat queued
    add_ev(0, 1, 0); add_ev(5, 1, 0);
    mute_from = 3; mute_to = 5;
    add_seg(0, 2, P_DO, 1, 0);  add_seg(3, 5, 0, 1, 0);
    add_seg(6, 7, P_DO, 1, 0);  add_seg(8, 9, 0, 1, 0);
    add_seg(10, 13, P_SO, 1, 0);
    run("mute", 14);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst", freq_data, tone_on, busy, done, 18'd0, 1'b0, 1'b0, 1'b0);
    @(posedge sys_clk);
    #1;
    check("rst_hold", freq_data, tone_on, busy, done, 18'd0, 1'b0, 1'b0, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // After reset: idle until a new event, nothing queued survives
    add_ev(3, 1, 0);
    add_seg(3, 10, P_DO, 1, 0);  add_seg(11, 12, 0, 1, 0);
    add_seg(13, 20, P_SO, 1, 0); add_seg(21, 22, 0, 1, 0);
    add_seg(23, 23, 0, 0, 1);
    run("post_rst", 30);

    // Minimum NOTE_LEN with no gap: notes are back to back
    for (int e = 0; e < 6; e++) begin
      @(negedge sys_clk);
      crash_evt = (e == 0);
      @(posedge sys_clk);
      #1;
      case (e)
        0:       begin ef = P_SO; eb = 1'b1; ed = 1'b0; end
        1:       begin ef = P_MI; eb = 1'b1; ed = 1'b0; end
        2:       begin ef = P_DO; eb = 1'b1; ed = 1'b0; end
        3:       begin ef = 18'd0; eb = 1'b0; ed = 1'b1; end
        default: begin ef = 18'd0; eb = 1'b0; ed = 1'b0; end
      endcase
      check($sformatf("nogap@%0d", e), freq0, tone0, busy0, done0,
            ef, (ef != 18'd0), eb, ed);
    end
    @(negedge sys_clk);
    crash_evt = 1'b0;
    repeat (40) @(posedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
